// File: rtl/video_timing_pkg.sv
// Shared types for the video stream timing block.
//   rgb_t         : 24-bit pixel {R,G,B}
//   stream_beat_t : one stream beat as stored in the pixel FIFO {user (SOF), data}
//   state_t       : frame-lock state (WAIT_SOF until the stream SOF meets the
//                   raster's first active pixel, then RUN)
`timescale 1ns/1ps
package video_timing_pkg;

  typedef logic [23:0] rgb_t;

  typedef struct packed {
    logic user;
    rgb_t data;
  } stream_beat_t;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } state_t;

endpackage

// File: rtl/video_pixel_fifo.sv
// First-word-fall-through synchronous FIFO for stream beats.
// The head entry is visible on `head` whenever `empty` is low; `pop`
// consumes it. Pushes are ignored when full, pops are ignored when empty.
// Ports:
//   clock, reset_n      : pixel clock, asynchronous active-low reset
//   push, push_beat     : write request and beat to store
//   pop                 : consume the head entry
//   head                : current head entry (valid when !empty)
//   full, empty         : occupancy flags
`timescale 1ns/1ps
module video_pixel_fifo
  import video_timing_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  stream_beat_t push_beat,
  input  logic         pop,
  output stream_beat_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  stream_beat_t mem_q [DEPTH];

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    // Pointers wrap naturally because DEPTH is a power of two.
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are meaningful, so clearing the array would only cost logic.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_beat;
  end

endmodule

// File: rtl/video_stream_timing.sv
// Converts a valid/ready RGB pixel stream (SOF on in_user) into raster
// timing for dvi_out. A free-running h/v counter pair generates the raster;
// a FWFT pixel FIFO absorbs source burstiness, and a frame-lock FSM aligns
// the stream SOF with the raster's first active pixel, falling back to
// WAIT_SOF on FIFO underflow or SOF misalignment.
// Ports:
//   clock, reset_n               : pixel clock, asynchronous active-low reset
//   in_data/in_user/in_valid     : stream input (in_user = start of frame)
//   in_ready                     : stream back-pressure (!full, low in reset)
//   video_de/hsync/vsync/data    : registered raster outputs, 1 clock after
//                                  the (h,v) position they describe
//   locked                       : frame lock achieved (state RUN)
//   underflow, sync_error        : sticky error flags, cleared by reset only
// Optional build macro VIDEO_STREAM_TIMING_STATS_EN adds:
//   underflow_count              : saturating count of underflow events
//   frame_count                  : wrapping count of frames started in RUN
`timescale 1ns/1ps
module video_stream_timing
  import video_timing_pkg::*;
#(
  parameter int   HSYNC       = 192,
  parameter int   HBACK       = 304,
  parameter int   HACTIVE     = 1600,
  parameter int   HFRONT      = 64,
  parameter int   VSYNC       = 3,
  parameter int   VBACK       = 46,
  parameter int   VACTIVE     = 1200,
  parameter int   VFRONT      = 1,
  parameter int   FIFO_DEPTH  = 64,
  parameter rgb_t BLANK_COLOR = 24'h000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [23:0] in_data,
  input  logic        in_user,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        video_de,
  output logic        video_hsync,
  output logic        video_vsync,
  output logic [23:0] video_data,
  output logic        locked,
  output logic        underflow,
  output logic        sync_error
`ifdef VIDEO_STREAM_TIMING_STATS_EN
  ,
  output logic [15:0] underflow_count,
  output logic [15:0] frame_count
`endif
);

  localparam int HTOTAL = HSYNC + HBACK + HACTIVE + HFRONT;
  localparam int VTOTAL = VSYNC + VBACK + VACTIVE + VFRONT;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_LAST      = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END  = HW'(HSYNC);
  localparam logic [HW-1:0] H_ACT_START = HW'(HSYNC + HBACK);
  localparam logic [HW-1:0] H_ACT_END   = HW'(HSYNC + HBACK + HACTIVE);
  localparam logic [VW-1:0] V_LAST      = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(VSYNC);
  localparam logic [VW-1:0] V_ACT_START = VW'(VSYNC + VBACK);
  localparam logic [VW-1:0] V_ACT_END   = VW'(VSYNC + VBACK + VACTIVE);

  // Raster counters
  logic [HW-1:0] h_count_q, h_count_d;
  logic [VW-1:0] v_count_q, v_count_d;
  logic          hs, vs, de, first;

  // Frame-lock state and registered outputs
  state_t        state_q, state_d;
  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  rgb_t          data_q, data_d;
  logic          underflow_q, underflow_d;
  logic          sync_error_q, sync_error_d;
  logic          ready_en_q;

  // FIFO interface
  stream_beat_t  fifo_head;
  logic          fifo_full, fifo_empty, fifo_pop;

  video_pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (in_valid && in_ready),
    .push_beat ({in_user, in_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ready_en_q keeps in_ready low while reset is asserted.
  assign in_ready    = ready_en_q && !fifo_full;
  assign video_de    = de_q;
  assign video_hsync = hsync_q;
  assign video_vsync = vsync_q;
  assign video_data  = data_q;
  assign locked      = (state_q == RUN);
  assign underflow   = underflow_q;
  assign sync_error  = sync_error_q;

  // Raster decode of the current (h,v) position.
  always_comb begin
    hs    = (h_count_q < H_SYNC_END);
    vs    = (v_count_q < V_SYNC_END);
    de    = (h_count_q >= H_ACT_START) && (h_count_q < H_ACT_END) &&
            (v_count_q >= V_ACT_START) && (v_count_q < V_ACT_END);
    first = de && (h_count_q == H_ACT_START) && (v_count_q == V_ACT_START);
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    h_count_d    = (h_count_q == H_LAST) ? '0 : h_count_q + HW'(1);
    v_count_d    = v_count_q;
    if (h_count_q == H_LAST) begin
      v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + VW'(1);
    end
    state_d      = state_q;
    fifo_pop     = 1'b0;
    de_d         = de;
    hsync_d      = hs;
    vsync_d      = vs;
    data_d       = '0;
    underflow_d  = underflow_q;
    sync_error_d = sync_error_q;

    case (state_q)
      WAIT_SOF: begin
        if (de) data_d = BLANK_COLOR;
        if (!fifo_empty) begin
          if (!fifo_head.user) begin
            // Drain beats until a SOF reaches the head.
            fifo_pop = 1'b1;
          end else if (first) begin
            fifo_pop = 1'b1;
            data_d   = fifo_head.data;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (de) begin
          if (fifo_empty) begin
            data_d      = BLANK_COLOR;
            underflow_d = 1'b1;
            state_d     = WAIT_SOF;
          end else if (first != fifo_head.user) begin
            // Late SOF (first without user) or early SOF (user before first):
            // nothing is popped, so an early SOF stays at the head for relock.
            data_d       = BLANK_COLOR;
            sync_error_d = 1'b1;
            state_d      = WAIT_SOF;
          end else begin
            fifo_pop = 1'b1;
            data_d   = fifo_head.data;
          end
        end
      end
    endcase
  end

`ifdef VIDEO_STREAM_TIMING_STATS_EN
  logic [15:0] underflow_count_q, underflow_count_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        uf_event, frame_event;

  assign underflow_count = underflow_count_q;
  assign frame_count     = frame_count_q;

  always_comb begin
    uf_event          = (state_q == RUN) && de && fifo_empty;
    // A SOF at the head on `first` is taken in both states.
    frame_event       = first && !fifo_empty && fifo_head.user;
    underflow_count_d = underflow_count_q;
    if (uf_event && (underflow_count_q != 16'hFFFF)) begin
      underflow_count_d = underflow_count_q + 16'd1;
    end
    frame_count_d     = frame_event ? frame_count_q + 16'd1 : frame_count_q;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_count_q         <= '0;
      v_count_q         <= '0;
      state_q           <= WAIT_SOF;
      de_q              <= 1'b0;
      hsync_q           <= 1'b0;
      vsync_q           <= 1'b0;
      data_q            <= '0;
      underflow_q       <= 1'b0;
      sync_error_q      <= 1'b0;
      ready_en_q        <= 1'b0;
`ifdef VIDEO_STREAM_TIMING_STATS_EN
      underflow_count_q <= '0;
      frame_count_q     <= '0;
`endif
    end else begin
      h_count_q         <= h_count_d;
      v_count_q         <= v_count_d;
      state_q           <= state_d;
      de_q              <= de_d;
      hsync_q           <= hsync_d;
      vsync_q           <= vsync_d;
      data_q            <= data_d;
      underflow_q       <= underflow_d;
      sync_error_q      <= sync_error_d;
      ready_en_q        <= 1'b1;
`ifdef VIDEO_STREAM_TIMING_STATS_EN
      underflow_count_q <= underflow_count_d;
      frame_count_q     <= frame_count_d;
`endif
    end
  end

endmodule
